// File: rtl/axi_ram_rd_if.sv
// AXI4 read-channel front end for a single-port RAM: bursts are expanded into per-beat RAM read commands.
// Command path is registered; R path is combinational or, with PIPELINE_OUTPUT=1, a two-entry skid buffer.
// Backpressure: cmd stalls on ram_rd_cmd_ready; R stalls on s_axi_rready independently of command issue.
module axi_ram_rd_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 16,
  parameter int STRB_WIDTH      = DATA_WIDTH / 8,
  parameter int ID_WIDTH        = 8,
  parameter int ARUSER_ENABLE   = 0,
  parameter int ARUSER_WIDTH    = 1,
  parameter int RUSER_ENABLE    = 0,
  parameter int RUSER_WIDTH     = 1,
  parameter int PIPELINE_OUTPUT = 0
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,

  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,

  output logic [ID_WIDTH-1:0]     ram_rd_cmd_id,
  output logic [ADDR_WIDTH-1:0]   ram_rd_cmd_addr,
  output logic                    ram_rd_cmd_lock,
  output logic [3:0]              ram_rd_cmd_cache,
  output logic [2:0]              ram_rd_cmd_prot,
  output logic [3:0]              ram_rd_cmd_qos,
  output logic [3:0]              ram_rd_cmd_region,
  output logic [ARUSER_WIDTH-1:0] ram_rd_cmd_auser,
  output logic                    ram_rd_cmd_en,
  output logic                    ram_rd_cmd_last,
  input  logic                    ram_rd_cmd_ready,

  input  logic [ID_WIDTH-1:0]     ram_rd_resp_id,
  input  logic [DATA_WIDTH-1:0]   ram_rd_resp_data,
  input  logic                    ram_rd_resp_last,
  input  logic [RUSER_WIDTH-1:0]  ram_rd_resp_user,
  input  logic                    ram_rd_resp_valid,
  output logic                    ram_rd_resp_ready
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_MAX    = 3'($clog2(STRB_WIDTH));

  generate
    if ((STRB_WIDTH * 8 != DATA_WIDTH) || (DATA_WIDTH % STRB_WIDTH != 0) ||
        ((STRB_WIDTH & (STRB_WIDTH - 1)) != 0)) begin : g_bad_params
      $error("axi_ram_rd_if: DATA_WIDTH must be 8*STRB_WIDTH with STRB_WIDTH a power of two");
    end
  endgenerate

  typedef enum logic [0:0] {ST_IDLE, ST_BURST} state_t;

  state_t                  state_q, state_d;
  logic                    arready_q, arready_d;
  logic                    cmd_vld_q, cmd_vld_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    lock_q, lock_d;
  logic [3:0]              cache_q, cache_d;
  logic [2:0]              prot_q, prot_d;
  logic [3:0]              qos_q, qos_d;
  logic [3:0]              region_q, region_d;
  logic [ARUSER_WIDTH-1:0] aruser_q, aruser_d;
  logic [7:0]              count_q, count_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;
  logic                    last_q, last_d;
  logic                    cmd_xfer;

  assign cmd_xfer = cmd_vld_q && ram_rd_cmd_ready;

  always_comb begin
    state_d   = state_q;
    arready_d = 1'b0;
    cmd_vld_d = cmd_vld_q;
    id_d      = id_q;
    addr_d    = addr_q;
    lock_d    = lock_q;
    cache_d   = cache_q;
    prot_d    = prot_q;
    qos_d     = qos_q;
    region_d  = region_q;
    aruser_d  = aruser_q;
    count_d   = count_q;
    size_d    = size_q;
    burst_d   = burst_q;
    last_d    = last_q;
    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          id_d      = s_axi_arid;
          addr_d    = s_axi_araddr;
          lock_d    = s_axi_arlock;
          cache_d   = s_axi_arcache;
          prot_d    = s_axi_arprot;
          qos_d     = s_axi_arqos;
          region_d  = s_axi_arregion;
          aruser_d  = s_axi_aruser;
          count_d   = s_axi_arlen;
          size_d    = (s_axi_arsize > SIZE_MAX) ? SIZE_MAX : s_axi_arsize;
          // WRAP is folded into INCR so only FIXED needs special handling later
          burst_d   = (s_axi_arburst == BURST_FIXED) ? BURST_FIXED : BURST_INCR;
          last_d    = (s_axi_arlen == 8'd0);
          cmd_vld_d = 1'b1;
          arready_d = 1'b0;
          state_d   = ST_BURST;
        end
      end
      ST_BURST: begin
        if (cmd_xfer) begin
          if (burst_q != BURST_FIXED) begin
            addr_d = addr_q + (ADDR_WIDTH'(1) << size_q);
          end
          count_d = count_q - 8'd1;
          last_d  = (count_q == 8'd1);
          if (count_q == 8'd0) begin
            cmd_vld_d = 1'b0;
            arready_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      cmd_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      cmd_vld_q <= cmd_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q     <= id_d;
    addr_q   <= addr_d;
    lock_q   <= lock_d;
    cache_q  <= cache_d;
    prot_q   <= prot_d;
    qos_q    <= qos_d;
    region_q <= region_d;
    aruser_q <= aruser_d;
    count_q  <= count_d;
    size_q   <= size_d;
    burst_q  <= burst_d;
    last_q   <= last_d;
  end

  assign s_axi_arready     = arready_q;
  assign ram_rd_cmd_id     = id_q;
  assign ram_rd_cmd_addr   = addr_q;
  assign ram_rd_cmd_lock   = lock_q;
  assign ram_rd_cmd_cache  = cache_q;
  assign ram_rd_cmd_prot   = prot_q;
  assign ram_rd_cmd_qos    = qos_q;
  assign ram_rd_cmd_region = region_q;
  assign ram_rd_cmd_auser  = (ARUSER_ENABLE != 0) ? aruser_q : '0;
  assign ram_rd_cmd_en     = cmd_vld_q;
  assign ram_rd_cmd_last   = last_q;
  assign s_axi_rresp       = 2'b00;

  generate
    if (PIPELINE_OUTPUT != 0) begin : g_r_pipe
      logic                   out_vld_q, out_vld_d;
      logic                   skid_vld_q, skid_vld_d;
      logic                   resp_rdy_q;
      logic                   resp_acc;
      logic                   load_out_in, load_out_skid, load_skid;
      logic [ID_WIDTH-1:0]    out_id_q, skid_id_q;
      logic [DATA_WIDTH-1:0]  out_data_q, skid_data_q;
      logic                   out_last_q, skid_last_q;
      logic [RUSER_WIDTH-1:0] out_user_q, skid_user_q;

      // resp_rdy_q tracks skid emptiness, so an accepted beat always has somewhere to land
      always_comb begin
        resp_acc      = ram_rd_resp_valid && resp_rdy_q;
        out_vld_d     = out_vld_q;
        skid_vld_d    = skid_vld_q;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (!out_vld_q || s_axi_rready) begin
          if (skid_vld_q) begin
            out_vld_d     = 1'b1;
            load_out_skid = 1'b1;
            skid_vld_d    = 1'b0;
          end else begin
            out_vld_d   = resp_acc;
            load_out_in = resp_acc;
          end
        end else if (resp_acc) begin
          skid_vld_d = 1'b1;
          load_skid  = 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          out_vld_q  <= 1'b0;
          skid_vld_q <= 1'b0;
          resp_rdy_q <= 1'b0;
        end else begin
          out_vld_q  <= out_vld_d;
          skid_vld_q <= skid_vld_d;
          resp_rdy_q <= !skid_vld_d;
        end
      end

      always_ff @(posedge clk) begin
        if (load_out_in) begin
          out_id_q   <= ram_rd_resp_id;
          out_data_q <= ram_rd_resp_data;
          out_last_q <= ram_rd_resp_last;
          out_user_q <= ram_rd_resp_user;
        end else if (load_out_skid) begin
          out_id_q   <= skid_id_q;
          out_data_q <= skid_data_q;
          out_last_q <= skid_last_q;
          out_user_q <= skid_user_q;
        end
        if (load_skid) begin
          skid_id_q   <= ram_rd_resp_id;
          skid_data_q <= ram_rd_resp_data;
          skid_last_q <= ram_rd_resp_last;
          skid_user_q <= ram_rd_resp_user;
        end
      end

      assign s_axi_rid         = out_id_q;
      assign s_axi_rdata       = out_data_q;
      assign s_axi_rlast       = out_last_q;
      assign s_axi_ruser       = (RUSER_ENABLE != 0) ? out_user_q : '0;
      assign s_axi_rvalid      = out_vld_q;
      assign ram_rd_resp_ready = resp_rdy_q;
    end else begin : g_r_comb
      assign s_axi_rid         = ram_rd_resp_id;
      assign s_axi_rdata       = ram_rd_resp_data;
      assign s_axi_rlast       = ram_rd_resp_last;
      assign s_axi_ruser       = (RUSER_ENABLE != 0) ? ram_rd_resp_user : '0;
      assign s_axi_rvalid      = ram_rd_resp_valid;
      assign ram_rd_resp_ready = s_axi_rready;
    end
  endgenerate

endmodule

// File: tb/tb_axi_ram_rd_if.sv
// Scoreboard bench for axi_ram_rd_if (registered R path): expected commands and R beats are
// queued when a burst is issued; monitors pop and compare on each handshake.
module tb_axi_ram_rd_if;

  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [1:0]  INCR  = 2'b01;
  localparam logic [15:0] SB    = {1'b1, 4'h3, 3'h2, 4'h5, 4'h9};

  typedef struct packed {
    logic [7:0]  id;
    logic [15:0] addr;
    logic        last;
  } cmd_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic        last;
  } rbeat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_axi_arid;
  logic [15:0] s_axi_araddr;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_arlock;
  logic [3:0]  s_axi_arcache;
  logic [2:0]  s_axi_arprot;
  logic [3:0]  s_axi_arqos;
  logic [3:0]  s_axi_arregion;
  logic [0:0]  s_axi_aruser;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [7:0]  s_axi_rid;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rlast;
  logic [0:0]  s_axi_ruser;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [7:0]  ram_rd_cmd_id;
  logic [15:0] ram_rd_cmd_addr;
  logic        ram_rd_cmd_lock;
  logic [3:0]  ram_rd_cmd_cache;
  logic [2:0]  ram_rd_cmd_prot;
  logic [3:0]  ram_rd_cmd_qos;
  logic [3:0]  ram_rd_cmd_region;
  logic [0:0]  ram_rd_cmd_auser;
  logic        ram_rd_cmd_en;
  logic        ram_rd_cmd_last;
  logic        ram_rd_cmd_ready;
  logic [7:0]  ram_rd_resp_id;
  logic [31:0] ram_rd_resp_data;
  logic        ram_rd_resp_last;
  logic [0:0]  ram_rd_resp_user;
  logic        ram_rd_resp_valid;
  logic        ram_rd_resp_ready;

  cmd_t   cmd_q[$];
  rbeat_t r_q[$];
  cmd_t   pend_q[$];
  int     errors = 0;
  int     checks = 0;
  int     cmd_cnt = 0;
  bit     ram_on = 1'b0;

  axi_ram_rd_if #(.PIPELINE_OUTPUT(1)) dut (
    .clk(clk), .rst(rst),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
    .s_axi_arregion(s_axi_arregion), .s_axi_aruser(s_axi_aruser),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_ruser(s_axi_ruser), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .ram_rd_cmd_id(ram_rd_cmd_id), .ram_rd_cmd_addr(ram_rd_cmd_addr),
    .ram_rd_cmd_lock(ram_rd_cmd_lock), .ram_rd_cmd_cache(ram_rd_cmd_cache),
    .ram_rd_cmd_prot(ram_rd_cmd_prot), .ram_rd_cmd_qos(ram_rd_cmd_qos),
    .ram_rd_cmd_region(ram_rd_cmd_region), .ram_rd_cmd_auser(ram_rd_cmd_auser),
    .ram_rd_cmd_en(ram_rd_cmd_en), .ram_rd_cmd_last(ram_rd_cmd_last),
    .ram_rd_cmd_ready(ram_rd_cmd_ready),
    .ram_rd_resp_id(ram_rd_resp_id), .ram_rd_resp_data(ram_rd_resp_data),
    .ram_rd_resp_last(ram_rd_resp_last), .ram_rd_resp_user(ram_rd_resp_user),
    .ram_rd_resp_valid(ram_rd_resp_valid), .ram_rd_resp_ready(ram_rd_resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic [7:0] id, input logic [15:0] addr, input logic last);
    cmd_t c;
    c.id = id; c.addr = addr; c.last = last;
    cmd_q.push_back(c);
  endtask

  task automatic push_r(input logic [7:0] id, input logic [31:0] data, input logic last);
    rbeat_t b;
    b.id = id; b.data = data; b.last = last;
    r_q.push_back(b);
  endtask

  // Caller sits between edges; returns one step after the handshake edge.
  task automatic send_ar(input logic [7:0] id, input logic [15:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, output int waits);
    bit got;
    got = 1'b0;
    waits = 0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
    s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      if (s_axi_arready) got = 1'b1;
      else begin
        @(negedge clk);
        waits++;
      end
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    if (!got) chk("ar_handshake_timeout", 0, 1);
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 300 && (cmd_q.size() != 0 || r_q.size() != 0); i++) @(negedge clk);
    chk(nm, cmd_q.size() + r_q.size(), 0);
    cmd_q.delete();
    r_q.delete();
    @(posedge clk); #1;
  endtask

  // Command monitor: while a burst is expected, outputs must match the head entry even when stalled.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cmd_q.size() != 0) begin
          chk("arready_busy", s_axi_arready, 0);
          if (ram_rd_cmd_en) begin
            chk("cmd_addr", ram_rd_cmd_addr, cmd_q[0].addr);
            chk("cmd_id", ram_rd_cmd_id, cmd_q[0].id);
            chk("cmd_last", ram_rd_cmd_last, cmd_q[0].last);
            chk("cmd_sideband", {ram_rd_cmd_lock, ram_rd_cmd_cache, ram_rd_cmd_prot,
                                 ram_rd_cmd_qos, ram_rd_cmd_region}, SB);
            chk("cmd_auser", ram_rd_cmd_auser, 0);
            if (ram_rd_cmd_ready) begin
              void'(cmd_q.pop_front());
              cmd_cnt++;
            end
          end
        end else begin
          chk("cmd_idle", ram_rd_cmd_en, 0);
        end
      end
    end
  end

  // R monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && s_axi_rvalid && s_axi_rready) begin
        if (r_q.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          chk("r_id", s_axi_rid, r_q[0].id);
          chk("r_data", s_axi_rdata, r_q[0].data);
          chk("r_last", s_axi_rlast, r_q[0].last);
          chk("r_resp", s_axi_rresp, 0);
          chk("r_user", s_axi_ruser, 0);
          void'(r_q.pop_front());
        end
      end
    end
  end

  // RAM model: one response per accepted command, data derived from the command address.
  initial begin
    bit acc;
    cmd_t c;
    ram_rd_resp_valid = 1'b0;
    ram_rd_resp_id    = '0;
    ram_rd_resp_data  = '0;
    ram_rd_resp_last  = 1'b0;
    ram_rd_resp_user  = '0;
    forever begin
      @(negedge clk);
      acc = ram_rd_resp_valid && ram_rd_resp_ready;
      if (ram_on && !rst && ram_rd_cmd_en && ram_rd_cmd_ready) begin
        c.id = ram_rd_cmd_id; c.addr = ram_rd_cmd_addr; c.last = ram_rd_cmd_last;
        pend_q.push_back(c);
      end
      @(posedge clk); #1;
      if (acc && pend_q.size() != 0) void'(pend_q.pop_front());
      if (ram_on && pend_q.size() != 0) begin
        ram_rd_resp_valid = 1'b1;
        ram_rd_resp_id    = pend_q[0].id;
        ram_rd_resp_data  = {16'hA5A5, pend_q[0].addr};
        ram_rd_resp_last  = pend_q[0].last;
      end else begin
        ram_rd_resp_valid = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int c0;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b0;

    rst = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = INCR; s_axi_arvalid = 1'b0;
    {s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion} = SB;
    s_axi_aruser = 1'b1;
    s_axi_rready = 1'b1;
    ram_rd_cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_arready", s_axi_arready, 0);
    chk("rst_cmd_en", ram_rd_cmd_en, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);
    chk("rst_resp_ready", ram_rd_resp_ready, 0);
    @(negedge clk);
    chk("idle_arready", s_axi_arready, 1);
    chk("idle_resp_ready", ram_rd_resp_ready, 1);

    // INCR, 4 beats on consecutive cycles
    send_ar(8'h11, 16'h0100, 8'd3, 3'd2, INCR, w);
    push_cmd(8'h11, 16'h0100, 1'b0);
    push_cmd(8'h11, 16'h0104, 1'b0);
    push_cmd(8'h11, 16'h0108, 1'b0);
    push_cmd(8'h11, 16'h010C, 1'b1);
    c0 = cmd_cnt;
    repeat (4) @(negedge clk);
    chk("incr_consecutive", cmd_cnt - c0, 4);
    wait_done("incr_done");

    // FIXED holds the address
    send_ar(8'h22, 16'h0040, 8'd2, 3'd2, FIXED, w);
    push_cmd(8'h22, 16'h0040, 1'b0);
    push_cmd(8'h22, 16'h0040, 1'b0);
    push_cmd(8'h22, 16'h0040, 1'b1);
    wait_done("fixed_done");

    // arsize=3 clamps to a 4-byte step
    send_ar(8'h23, 16'h0080, 8'd2, 3'd3, INCR, w);
    push_cmd(8'h23, 16'h0080, 1'b0);
    push_cmd(8'h23, 16'h0084, 1'b0);
    push_cmd(8'h23, 16'h0088, 1'b1);
    wait_done("clamp_done");

    // cmd_ready 1,0,0,1 while bursting
    send_ar(8'h33, 16'h0200, 8'd3, 3'd2, INCR, w);
    push_cmd(8'h33, 16'h0200, 1'b0);
    push_cmd(8'h33, 16'h0204, 1'b0);
    push_cmd(8'h33, 16'h0208, 1'b0);
    push_cmd(8'h33, 16'h020C, 1'b1);
    @(posedge clk); #1 ram_rd_cmd_ready = 1'b0;
    @(posedge clk); #1 ram_rd_cmd_ready = 1'b0;
    @(posedge clk); #1 ram_rd_cmd_ready = 1'b1;
    wait_done("stall_done");
    @(negedge clk);
    chk("stall_arready_after", s_axi_arready, 1);

    // address wrap at top of space, then single-beat and back-to-back AR
    send_ar(8'h44, 16'hFFFC, 8'd1, 3'd2, INCR, w);
    push_cmd(8'h44, 16'hFFFC, 1'b0);
    push_cmd(8'h44, 16'h0000, 1'b1);
    wait_done("wrap_done");
    send_ar(8'h45, 16'h1234, 8'd0, 3'd2, INCR, w);
    push_cmd(8'h45, 16'h1234, 1'b1);
    send_ar(8'h46, 16'h2000, 8'd0, 3'd2, INCR, w);
    push_cmd(8'h46, 16'h2000, 1'b1);
    chk("b2b_ar_wait", w, 2);
    wait_done("single_done");

    // 8-beat read through the skid buffer with rready 1,1,0,0,...
    ram_on = 1'b1;
    send_ar(8'h5A, 16'h0300, 8'd7, 3'd2, INCR, w);
    for (int i = 0; i < 8; i++) begin
      push_cmd(8'h5A, 16'h0300 + 16'(4 * i), i == 7);
      push_r(8'h5A, {16'hA5A5, 16'h0300 + 16'(4 * i)}, i == 7);
    end
    for (int k = 0; k < 200 && r_q.size() != 0; k++) begin
      s_axi_rready = pat[k % 4];
      @(posedge clk); #1;
    end
    s_axi_rready = 1'b1;
    wait_done("rpipe_done");
    ram_on = 1'b0;
    pend_q.delete();

    // reset in the middle of a 16-beat burst
    send_ar(8'h66, 16'h0400, 8'd15, 3'd2, INCR, w);
    for (int i = 0; i < 16; i++) push_cmd(8'h66, 16'h0400 + 16'(4 * i), i == 15);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    cmd_q.delete();
    r_q.delete();
    @(negedge clk);
    chk("midrst_cmd_en", ram_rd_cmd_en, 0);
    chk("midrst_rvalid", s_axi_rvalid, 0);
    chk("midrst_arready", s_axi_arready, 0);
    @(negedge clk);
    chk("midrst_arready_rise", s_axi_arready, 1);
    send_ar(8'h67, 16'h0500, 8'd1, 3'd2, INCR, w);
    push_cmd(8'h67, 16'h0500, 1'b0);
    push_cmd(8'h67, 16'h0504, 1'b1);
    wait_done("post_rst_done");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
